universal_shift_register: RTL and testbench

Parametrised universal shift register with an integrated burst serializer. It supports hold, bidirectional logical shift, rotate, arithmetic shift right, parallel load and clear under a mode select. A start/busy/done handshake loads a word and shifts it out over exactly N cycles without per-cycle mode control. It is the general-purpose successor to the single-direction parallel-load shift register. Typical uses are serial links, SPI-style transmitters and bit-manipulation datapaths.

---
 rtl/universal_shift_register_if.sv | 25 ++
 rtl/universal_shift_register.sv | 81 ++++++++
 tb/tb_universal_shift_register.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/universal_shift_register_if.sv
// Datapath and burst-handshake bundle for the universal shift register.
// The master drives the controls and the slave returns status and data.
interface universal_shift_register_if #(
  parameter int N = 8
);
  logic [2:0]   mode;
  logic [N-1:0] d;
  logic         s_in_msb;
  logic         s_in_lsb;
  logic         start;
  logic         busy;
  logic         done;
  logic         s_out;
  logic [N-1:0] q;

  modport master (
    output mode, d, s_in_msb, s_in_lsb, start,
    input  busy, done, s_out, q
  );

  modport slave (
    input  mode, d, s_in_msb, s_in_lsb, start,
    output busy, done, s_out, q
  );
endinterface

// File: rtl/universal_shift_register.sv
// Universal shift register with an N-cycle burst serializer. Mode ops land on q one cycle after sampling.
// A burst runs N cycles, and done pulses once afterwards. Inputs are ignored while busy; there is no backpressure.
module universal_shift_register #(
  parameter int N         = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  universal_shift_register_if.slave bus
);
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t       state_q;
  logic [CW-1:0] cnt_q;
  logic [N-1:0] q_q;
  logic [N-1:0] q_d;
  logic [N-1:0] burst_d;
  logic         busy_q;
  logic         done_q;

  always_comb begin
    burst_d = LSB_FIRST ? {bus.s_in_msb, q_q[N-1:1]} : {q_q[N-2:0], bus.s_in_lsb};
  end

  always_comb begin
    q_d = q_q;
    case (bus.mode)
      3'b000:  q_d = q_q;
      3'b001:  q_d = {bus.s_in_msb, q_q[N-1:1]};
      3'b010:  q_d = {q_q[N-2:0], bus.s_in_lsb};
      3'b011:  q_d = {q_q[0], q_q[N-1:1]};
      3'b100:  q_d = {q_q[N-2:0], q_q[N-1]};
      3'b101:  q_d = {q_q[N-1], q_q[N-1:1]};
      3'b110:  q_d = bus.d;
      default: q_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            q_q     <= bus.d;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end else begin
            q_q <= q_d;
          end
        end
        SHIFT: begin
          q_q   <= burst_d;
          cnt_q <= cnt_q + CW'(1);
          // The final shift retires the burst; done is asserted on the same edge that busy drops.
          if (cnt_q == LAST) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.q     = q_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.s_out = LSB_FIRST ? q_q[0] : q_q[N-1];
endmodule

// File: tb/tb_universal_shift_register.sv
// Bench for universal_shift_register: table-driven mode vectors plus burst, isolation, back-to-back and reset-abort sequences.
module tb_universal_shift_register;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] mode = '0;
  logic [7:0] d = '0;
  logic       s_in_msb = 1'b0;
  logic       s_in_lsb = 1'b0;
  logic       start = 1'b0;
  logic       sel = 1'b0;

  int errors = 0;
  int checks = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  universal_shift_register_if #(.N(8)) if0 ();
  universal_shift_register_if #(.N(8)) if1 ();

  assign if0.mode = mode;      assign if1.mode = mode;
  assign if0.d = d;            assign if1.d = d;
  assign if0.s_in_msb = s_in_msb; assign if1.s_in_msb = s_in_msb;
  assign if0.s_in_lsb = s_in_lsb; assign if1.s_in_lsb = s_in_lsb;
  assign if0.start = start && !sel;
  assign if1.start = start && sel;

  universal_shift_register #(.N(8), .LSB_FIRST(1'b1)) u_lsb (.clk(clk), .reset_n(reset_n), .bus(if0));
  universal_shift_register #(.N(8), .LSB_FIRST(1'b0)) u_msb (.clk(clk), .reset_n(reset_n), .bus(if1));

  logic       cur_busy, cur_done, cur_s_out;
  logic [7:0] cur_q;
  assign cur_busy  = sel ? if1.busy  : if0.busy;
  assign cur_done  = sel ? if1.done  : if0.done;
  assign cur_s_out = sel ? if1.s_out : if0.s_out;
  assign cur_q     = sel ? if1.q     : if0.q;

  typedef struct {
    string      name;
    logic [2:0] mode;
    logic [7:0] d;
    logic       msb;
    logic       lsb;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_pop(input string name, input logic act);
    logic e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, got %0b", name, act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        errors++;
        $display("FAIL %s: got %0b expected %0b", name, act, e);
      end
    end
  endtask

  // Caller is 1ns after an edge with the selected DUT idle. When chain is set, a new burst is requested in the done cycle.
  task automatic run_burst(input logic s, input logic [7:0] dat, input logic fill,
                           input logic perturb, input logic chain, input logic [7:0] next_dat);
    sel = s; d = dat; mode = 3'b000; start = 1'b1;
    s_in_msb = fill; s_in_lsb = fill;
    for (int k = 0; k < 8; k++) exp_q.push_back(s ? dat[7-k] : dat[k]);
    tick();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (perturb && k == 3) begin start = 1'b1; mode = 3'b111; d = 8'h00; end
      if (perturb && k == 4) begin start = 1'b0; mode = 3'b000; end
      check("burst_busy", {31'd0, cur_busy}, 32'd1);
      check("burst_nodone", {31'd0, cur_done}, 32'd0);
      check_pop("burst_s_out", cur_s_out);
      tick();
    end
    check("end_busy", {31'd0, cur_busy}, 32'd0);
    check("end_done", {31'd0, cur_done}, 32'd1);
    check("end_q", {24'd0, cur_q}, {24'd0, {8{fill}}});
    if (chain) begin d = next_dat; start = 1'b1; end
    tick();
    start = 1'b0;
    if (chain) begin
      check("chain_busy", {31'd0, cur_busy}, 32'd1);
      check("chain_q", {24'd0, cur_q}, {24'd0, next_dat});
    end else begin
      check("post_done", {31'd0, cur_done}, 32'd0);
      check("post_busy", {31'd0, cur_busy}, 32'd0);
    end
  endtask

  initial begin
    vecs[0] = '{"shr_fill1", 3'b001, 8'h00, 1'b1, 1'b0, 8'hDA};
    vecs[1] = '{"shl_fill0", 3'b010, 8'h00, 1'b0, 1'b0, 8'h68};
    vecs[2] = '{"ror",       3'b011, 8'h00, 1'b0, 1'b0, 8'h5A};
    vecs[3] = '{"rol",       3'b100, 8'h00, 1'b0, 1'b0, 8'h69};
    vecs[4] = '{"asr",       3'b101, 8'h00, 1'b0, 1'b0, 8'hDA};
    vecs[5] = '{"clear",     3'b111, 8'h5C, 1'b1, 1'b1, 8'h00};
    vecs[6] = '{"hold",      3'b000, 8'hFF, 1'b1, 1'b1, 8'hB4};
    vecs[7] = '{"shr_fill0", 3'b001, 8'h00, 1'b0, 1'b1, 8'h5A};
    vecs[8] = '{"shl_fill1", 3'b010, 8'h00, 1'b1, 1'b1, 8'h69};
    vecs[9] = '{"load",      3'b110, 8'h3C, 1'b0, 1'b0, 8'h3C};

    tick(); tick();
    reset_n = 1'b1;
    tick();
    mode = 3'b110; d = 8'hFF; s_in_msb = 1'b1; start = 1'b0;
    tick();
    mode = 3'b000;
    #2 reset_n = 1'b0;
    #1;
    check("rst_q", {24'd0, if0.q}, 32'd0);
    check("rst_busy", {31'd0, if0.busy}, 32'd0);
    check("rst_done", {31'd0, if0.done}, 32'd0);
    check("rst_s_out", {31'd0, if0.s_out}, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();

    sel = 1'b0;
    for (int i = 0; i < 10; i++) begin
      mode = 3'b110; d = 8'hB4;
      tick();
      mode = vecs[i].mode; d = vecs[i].d;
      s_in_msb = vecs[i].msb; s_in_lsb = vecs[i].lsb;
      tick();
      mode = 3'b000;
      check({"mode_", vecs[i].name}, {24'd0, cur_q}, {24'd0, vecs[i].exp});
      check({"mode_busy_", vecs[i].name}, {31'd0, cur_busy}, 32'd0);
    end

    run_burst(1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00);
    run_burst(1'b0, 8'hC3, 1'b1, 1'b1, 1'b0, 8'h00);
    run_burst(1'b1, 8'h81, 1'b0, 1'b0, 1'b0, 8'h00);

    run_burst(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1, 8'h3C);
    tick(); tick(); tick();
    #2 reset_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, cur_busy}, 32'd0);
    check("abort_done", {31'd0, cur_done}, 32'd0);
    check("abort_q", {24'd0, cur_q}, 32'd0);
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      check("abort_no_done", {31'd0, cur_done}, 32'd0);
    end
    check("abort_idle", {31'd0, cur_busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
